cpu6_core: RTL and testbench

- Multi-cycle 8-bit CPU core implementing a reduced Centurion CPU6 instruction subset over a single byte-wide bus with a 16-bit address.
- Sits between the system memory/IO decoder and the rest of the platform.
- Performs exactly one bus access (read or write) per clock.
- Reset vector is at 0xFD00; memory is big-endian.

---
 rtl/cpu6_pkg.sv | 67 ++++++
 rtl/cpu6_alu.sv | 52 +++++
 rtl/cpu6_core.sv | 204 ++++++++++++++++++++
 tb/tb_cpu6_core.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_pkg.sv
// Shared definitions for the cpu6_core slice: opcodes, FSM states,
// register indices, flag layout and per-opcode bus shape decode.
package cpu6_pkg;

    localparam logic [15:0] RESET_VECTOR  = 16'hFD00;
    localparam int unsigned NUM_REG_BYTES = 16;

    localparam logic [7:0] OP_NOP    = 8'h01;
    localparam logic [7:0] OP_BZ     = 8'h14;
    localparam logic [7:0] OP_BNZ    = 8'h15;
    localparam logic [7:0] OP_CLR    = 8'h22;
    localparam logic [7:0] OP_CLAW   = 8'h3A;
    localparam logic [7:0] OP_SLAW   = 8'h3D;
    localparam logic [7:0] OP_ADD    = 8'h40;
    localparam logic [7:0] OP_AND    = 8'h42;
    localparam logic [7:0] OP_AABW   = 8'h58;
    localparam logic [7:0] OP_JMP    = 8'h71;
    localparam logic [7:0] OP_LDAL_I = 8'h80;
    localparam logic [7:0] OP_LDAL_A = 8'h81;
    localparam logic [7:0] OP_LDAW_I = 8'h90;
    localparam logic [7:0] OP_LDAW_A = 8'h91;
    localparam logic [7:0] OP_STAL   = 8'hA1;
    localparam logic [7:0] OP_STAW   = 8'hB1;
    localparam logic [7:0] OP_LDBL_I = 8'hC0;
    localparam logic [7:0] OP_LDBL_A = 8'hC1;

    localparam logic [3:0] AH = 4'd0;
    localparam logic [3:0] AL = 4'd1;
    localparam logic [3:0] BH = 4'd2;
    localparam logic [3:0] BL = 4'd3;
    localparam logic [3:0] XH = 4'd4;
    localparam logic [3:0] XL = 4'd5;

    typedef enum logic [2:0] {FETCH, OPER, READ, EXEC, WRITE} state_e;

    typedef struct packed {
        logic z;
        logic m;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {ALU_ADD8, ALU_AND8, ALU_ADD16, ALU_SHL16} alu_op_e;

    // Byte counts for the OPER, READ and WRITE phases of one instruction.
    typedef struct packed {
        logic [1:0] oper;
        logic [1:0] rd;
        logic [1:0] wr;
    } shape_t;

    function automatic shape_t decode_shape(input logic [7:0] op);
        shape_t s;
        s = '0;
        case (op)
            OP_BZ, OP_BNZ, OP_CLR, OP_ADD, OP_AND, OP_LDAL_I, OP_LDBL_I: s.oper = 2'd1;
            OP_JMP, OP_LDAW_I: s.oper = 2'd2;
            OP_LDAL_A, OP_LDBL_A: begin s.oper = 2'd2; s.rd = 2'd1; end
            OP_LDAW_A: begin s.oper = 2'd2; s.rd = 2'd2; end
            OP_STAL: begin s.oper = 2'd2; s.wr = 2'd1; end
            OP_STAW: begin s.oper = 2'd2; s.wr = 2'd2; end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu6_alu.sv
// Combinational 8/16-bit add, 8-bit and, 16-bit shift-left with Z/M/C/V update.
module cpu6_alu
    import cpu6_pkg::*;
(
    input  alu_op_e     op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  flags_t      flags_i,
    output logic [15:0] res_o,
    output flags_t      flags_o
);

    logic [8:0]  sum8;
    logic [16:0] sum16;

    assign sum8  = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]};
    assign sum16 = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        res_o   = '0;
        flags_o = flags_i;
        case (op_i)
            ALU_ADD8: begin
                res_o     = {8'h00, sum8[7:0]};
                flags_o.c = sum8[8];
                flags_o.v = (a_i[7] == b_i[7]) && (sum8[7] != a_i[7]);
            end
            ALU_AND8: begin
                res_o     = {8'h00, a_i[7:0] & b_i[7:0]};
                flags_o.v = 1'b0;
            end
            ALU_ADD16: begin
                res_o     = sum16[15:0];
                flags_o.c = sum16[16];
                flags_o.v = (a_i[15] == b_i[15]) && (sum16[15] != a_i[15]);
            end
            ALU_SHL16: begin
                res_o     = {a_i[14:0], 1'b0};
                flags_o.c = a_i[15];
            end
            default: res_o = '0;
        endcase
        if (op_i == ALU_ADD16 || op_i == ALU_SHL16) begin
            flags_o.z = (res_o == 16'h0000);
            flags_o.m = res_o[15];
        end else begin
            flags_o.z = (res_o[7:0] == 8'h00);
            flags_o.m = res_o[7];
        end
    end

endmodule

// File: rtl/cpu6_core.sv
// Multi-cycle CPU6 subset core, one byte-wide bus access per clock.
// Define CPU6_TRACE_EN for simulation-only fetch/write trace output.
module cpu6_core
    import cpu6_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR  = cpu6_pkg::RESET_VECTOR,
    parameter int unsigned NUM_REG_BYTES = cpu6_pkg::NUM_REG_BYTES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data_in,
    output logic        write_en,
    output logic [15:0] address,
    output logic [7:0]  data_out
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] opnd_q, opnd_d;
    logic [15:0] rdat_q, rdat_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  regs_q [NUM_REG_BYTES];
    logic [7:0]  regs_d [NUM_REG_BYTES];
    flags_t      flags_q, flags_d;

    shape_t      shape, fetch_shape;
    logic [15:0] ea;
    logic [3:0]  src, dst;
    logic [7:0]  ld8;
    logic [15:0] ld16;
    alu_op_e     alu_op;
    logic [15:0] alu_a, alu_b, alu_res;
    flags_t      alu_flags;

    assign shape       = decode_shape(op_q);
    assign fetch_shape = decode_shape(data_in);
    assign ea          = opnd_q + {14'd0, cnt_q};
    assign src         = opnd_q[7:4];
    assign dst         = opnd_q[3:0];
    // Opcode bit 0 separates the absolute (memory) form of each load from the immediate form.
    assign ld8         = op_q[0] ? rdat_q[7:0] : opnd_q[7:0];
    assign ld16        = op_q[0] ? rdat_q : opnd_q;

    always_comb begin
        alu_op = ALU_ADD8;
        alu_a  = {8'h00, regs_q[dst]};
        alu_b  = {8'h00, regs_q[src]};
        case (op_q)
            OP_AND: alu_op = ALU_AND8;
            OP_AABW: begin
                alu_op = ALU_ADD16;
                alu_a  = {regs_q[AH], regs_q[AL]};
                alu_b  = {regs_q[BH], regs_q[BL]};
            end
            OP_SLAW: begin
                alu_op = ALU_SHL16;
                alu_a  = {regs_q[AH], regs_q[AL]};
            end
            default: alu_op = ALU_ADD8;
        endcase
    end

    cpu6_alu u_alu (
        .op_i    (alu_op),
        .a_i     (alu_a),
        .b_i     (alu_b),
        .flags_i (flags_q),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        rdat_d   = rdat_q;
        cnt_d    = cnt_q;
        regs_d   = regs_q;
        flags_d  = flags_q;
        write_en = 1'b0;
        data_out = '0;
        address  = pc_q;
        case (state_q)
            FETCH: begin
                op_d    = data_in;
                pc_d    = pc_q + 16'd1;
                opnd_d  = '0;
                cnt_d   = '0;
                state_d = (fetch_shape.oper != 2'd0) ? OPER : EXEC;
            end
            OPER: begin
                opnd_d = {opnd_q[7:0], data_in};
                pc_d   = pc_q + 16'd1;
                if (cnt_q + 2'd1 == shape.oper) begin
                    cnt_d   = '0;
                    state_d = (shape.rd != 2'd0) ? READ : EXEC;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            READ: begin
                address = ea;
                rdat_d  = {rdat_q[7:0], data_in};
                if (cnt_q + 2'd1 == shape.rd) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            EXEC: begin
                cnt_d   = '0;
                state_d = (shape.wr != 2'd0) ? WRITE : FETCH;
                case (op_q)
                    OP_BZ:  if (flags_q.z)  pc_d = pc_q + {{8{opnd_q[7]}}, opnd_q[7:0]};
                    OP_BNZ: if (!flags_q.z) pc_d = pc_q + {{8{opnd_q[7]}}, opnd_q[7:0]};
                    OP_CLR: begin
                        regs_d[dst] = '0;
                        flags_d.z   = 1'b1;
                        flags_d.m   = 1'b0;
                        flags_d.v   = 1'b0;
                    end
                    OP_CLAW: begin
                        regs_d[AH] = '0;
                        regs_d[AL] = '0;
                        flags_d.z  = 1'b1;
                        flags_d.m  = 1'b0;
                    end
                    OP_SLAW: begin
                        {regs_d[AH], regs_d[AL]} = alu_res;
                        flags_d = alu_flags;
                    end
                    OP_ADD, OP_AND: begin
                        regs_d[dst] = alu_res[7:0];
                        flags_d     = alu_flags;
                    end
                    OP_AABW: begin
                        {regs_d[BH], regs_d[BL]} = alu_res;
                        flags_d = alu_flags;
                    end
                    OP_JMP: pc_d = opnd_q;
                    OP_LDAL_I, OP_LDAL_A, OP_LDBL_I, OP_LDBL_A: begin
                        if (op_q[6]) regs_d[BL] = ld8;
                        else         regs_d[AL] = ld8;
                        flags_d.z = (ld8 == 8'h00);
                        flags_d.m = ld8[7];
                        flags_d.v = 1'b0;
                    end
                    OP_LDAW_I, OP_LDAW_A: begin
                        {regs_d[AH], regs_d[AL]} = ld16;
                        flags_d.z = (ld16 == 16'h0000);
                        flags_d.m = ld16[15];
                        flags_d.v = 1'b0;
                    end
                    default: pc_d = pc_q;
                endcase
            end
            WRITE: begin
                address  = ea;
                write_en = 1'b1;
                data_out = (op_q == OP_STAW && cnt_q == 2'd0) ? regs_q[AH] : regs_q[AL];
                if (cnt_q + 2'd1 == shape.wr) begin
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            op_q    <= '0;
            opnd_q  <= '0;
            rdat_q  <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            for (int unsigned i = 0; i < NUM_REG_BYTES; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            rdat_q  <= rdat_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            regs_q  <= regs_d;
        end
    end

`ifdef CPU6_TRACE_EN
    always_ff @(posedge clock) begin
        if (reset && state_q == FETCH) $display("[cpu6] fetch pc=%04h op=%02h", pc_q, data_in);
        if (reset && write_en)         $display("[cpu6] write %04h <= %02h", address, data_out);
    end
`endif

endmodule

// File: tb/tb_cpu6_core.sv
// Self-checking bench for cpu6_core against an instruction-level reference model.
module tb_cpu6_core;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in;
    logic        write_en;
    logic [15:0] address;
    logic [7:0]  data_out;

    cpu6_core dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .write_en (write_en),
        .address  (address),
        .data_out (data_out)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [65536];
    logic [7:0] mm  [65536];
    assign data_in = mem[address];

    logic [15:0] m_pc;
    logic [7:0]  m_r [16];
    logic        m_z, m_mf, m_c, m_v;

    typedef struct packed {
        logic [15:0]  addr;
        logic         we;
        logic [7:0]   data;
        logic         fetch;
        logic [127:0] regs;
        logic [3:0]   fl;
    } cyc_t;
    cyc_t expq[$];

    int tests;
    int fails;
    logic [15:0] ptr;

    function automatic int sx8(input logic [7:0] x);
        return (x > 8'd127) ? int'(x) - 256 : int'(x);
    endfunction

    function automatic int sx16(input logic [15:0] x);
        return (x > 16'd32767) ? int'(x) - 65536 : int'(x);
    endfunction

    task automatic poke(input logic [15:0] a, input logic [7:0] b);
        mem[a] = b;
        mm[a]  = b;
    endtask

    task automatic emit(input logic [7:0] b);
        poke(ptr, b);
        ptr = ptr + 16'd1;
    endtask

    task automatic clear_prog();
        for (int i = 16'hFD00; i < 16'hFD40; i++) poke(16'(i), 8'h00);
    endtask

    task automatic push(input logic [15:0] a, input logic we, input logic [7:0] d, input logic f);
        cyc_t e;
        e.addr = a; e.we = we; e.data = d; e.fetch = f;
        e.fl = {m_z, m_mf, m_c, m_v};
        for (int i = 0; i < 16; i++) e.regs[i*8 +: 8] = m_r[i];
        expq.push_back(e);
    endtask

    // One instruction: queue its cycle-by-cycle bus activity, then apply its effect.
    task automatic model_step();
        logic [7:0]  op, o1, v8, a8, b8, r8;
        logic [15:0] ea, v16, wa, wb, r16;
        int sum, ssum;
        o1 = '0; ea = '0; v8 = '0; v16 = '0;
        op = mm[m_pc];
        push(m_pc, 1'b0, 8'h00, 1'b1);
        m_pc = m_pc + 16'd1;
        if (op inside {8'h14, 8'h15, 8'h22, 8'h40, 8'h42, 8'h80, 8'hC0}) begin
            o1 = mm[m_pc]; push(m_pc, 1'b0, 8'h00, 1'b0); m_pc = m_pc + 16'd1;
        end
        if (op inside {8'h71, 8'h81, 8'h90, 8'h91, 8'hA1, 8'hB1, 8'hC1}) begin
            ea[15:8] = mm[m_pc]; push(m_pc, 1'b0, 8'h00, 1'b0); m_pc = m_pc + 16'd1;
            ea[7:0]  = mm[m_pc]; push(m_pc, 1'b0, 8'h00, 1'b0); m_pc = m_pc + 16'd1;
        end
        if (op == 8'h81 || op == 8'hC1) begin
            v8 = mm[ea]; push(ea, 1'b0, 8'h00, 1'b0);
        end
        if (op == 8'h91) begin
            v16[15:8] = mm[ea];         push(ea, 1'b0, 8'h00, 1'b0);
            v16[7:0]  = mm[ea + 16'd1]; push(ea + 16'd1, 1'b0, 8'h00, 1'b0);
        end
        push(m_pc, 1'b0, 8'h00, 1'b0);
        case (op)
            8'h14: if (m_z)  m_pc = m_pc + 16'(sx8(o1));
            8'h15: if (!m_z) m_pc = m_pc + 16'(sx8(o1));
            8'h22: begin m_r[o1[3:0]] = 8'h00; m_z = 1'b1; m_mf = 1'b0; m_v = 1'b0; end
            8'h3A: begin m_r[0] = 8'h00; m_r[1] = 8'h00; m_z = 1'b1; m_mf = 1'b0; end
            8'h3D: begin
                wa = {m_r[0], m_r[1]};
                m_c = wa[15];
                r16 = 16'((int'(wa) * 2) % 65536);
                {m_r[0], m_r[1]} = r16;
                m_z = (r16 == 16'h0000); m_mf = r16[15];
            end
            8'h40, 8'h42: begin
                a8 = m_r[o1[3:0]]; b8 = m_r[o1[7:4]];
                if (op == 8'h40) begin
                    sum  = int'(a8) + int'(b8);
                    r8   = 8'(sum % 256);
                    m_c  = (sum > 255);
                    ssum = sx8(a8) + sx8(b8);
                    m_v  = (ssum > 127) || (ssum < -128);
                end else begin
                    r8  = a8 & b8;
                    m_v = 1'b0;
                end
                m_r[o1[3:0]] = r8;
                m_z = (r8 == 8'h00); m_mf = r8[7];
            end
            8'h58: begin
                wa = {m_r[0], m_r[1]}; wb = {m_r[2], m_r[3]};
                sum  = int'(wa) + int'(wb);
                r16  = 16'(sum % 65536);
                m_c  = (sum > 65535);
                ssum = sx16(wa) + sx16(wb);
                m_v  = (ssum > 32767) || (ssum < -32768);
                {m_r[2], m_r[3]} = r16;
                m_z = (r16 == 16'h0000); m_mf = r16[15];
            end
            8'h71: m_pc = ea;
            8'h80, 8'h81, 8'hC0, 8'hC1: begin
                r8 = (op == 8'h80 || op == 8'hC0) ? o1 : v8;
                if (op >= 8'hC0) m_r[3] = r8; else m_r[1] = r8;
                m_z = (r8 == 8'h00); m_mf = r8[7]; m_v = 1'b0;
            end
            8'h90, 8'h91: begin
                r16 = (op == 8'h90) ? ea : v16;
                {m_r[0], m_r[1]} = r16;
                m_z = (r16 == 16'h0000); m_mf = r16[15]; m_v = 1'b0;
            end
            8'hA1: push(ea, 1'b1, m_r[1], 1'b0);
            8'hB1: begin
                push(ea, 1'b1, m_r[0], 1'b0);
                push(ea + 16'd1, 1'b1, m_r[1], 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic run_cycles(input int n, input string tag);
        cyc_t        e;
        logic [127:0] dr;
        logic [3:0]   df;
        for (int k = 0; k < n; k++) begin
            if (expq.size() == 0) model_step();
            e = expq.pop_front();
            tests++;
            if (address !== e.addr) begin
                fails++;
                $display("FAIL %s address cyc %0d: got %h want %h", tag, k, address, e.addr);
            end
            tests++;
            if (write_en !== e.we) begin
                fails++;
                $display("FAIL %s write_en cyc %0d: got %b want %b", tag, k, write_en, e.we);
            end
            if (e.we) begin
                tests++;
                if (data_out !== e.data) begin
                    fails++;
                    $display("FAIL %s data_out cyc %0d: got %h want %h", tag, k, data_out, e.data);
                end
                mm[e.addr] = e.data;
            end
            if (e.fetch) begin
                for (int i = 0; i < 16; i++) dr[i*8 +: 8] = dut.regs_q[i];
                df = dut.flags_q;
                tests++;
                if (dr !== e.regs) begin
                    fails++;
                    $display("FAIL %s regs cyc %0d: got %h want %h", tag, k, dr, e.regs);
                end
                tests++;
                if (df !== e.fl) begin
                    fails++;
                    $display("FAIL %s flags cyc %0d: got %b want %b", tag, k, df, e.fl);
                end
            end
            if (write_en === 1'b1) mem[address] = data_out;
            @(negedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        expq.delete();
        m_pc = 16'hFD00;
        for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
        m_z = 1'b0; m_mf = 1'b0; m_c = 1'b0; m_v = 1'b0;
        @(negedge clock);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_prog();
        do_reset();
        tests++;
        if (address !== 16'hFD00) begin fails++; $display("FAIL reset address: got %h want fd00", address); end
        tests++;
        if (write_en !== 1'b0) begin fails++; $display("FAIL reset write_en: got %b want 0", write_en); end
        tests++;
        if (data_out !== 8'h00) begin fails++; $display("FAIL reset data_out: got %h want 00", data_out); end
        release_reset();
        run_cycles(6, "reset_nop");
    endtask

    task automatic test_jmp_load_store();
        clear_prog();
        ptr = 16'hFD00; emit(8'h71); emit(8'h80); emit(8'h01);
        ptr = 16'h8001; emit(8'h80); emit(8'h48); emit(8'hA1); emit(8'hF2); emit(8'h01);
        do_reset();
        release_reset();
        run_cycles(4, "jmp");
        tests++;
        if (address !== 16'h8001) begin fails++; $display("FAIL jmp target: got %h want 8001", address); end
        run_cycles(7, "ldal");
        tests++;
        if (write_en !== 1'b1 || address !== 16'hF201 || data_out !== 8'h48) begin
            fails++;
            $display("FAIL stal write: got we=%b %h/%h want we=1 f201/48", write_en, address, data_out);
        end
        run_cycles(4, "stal");
    endtask

    task automatic test_word();
        clear_prog();
        ptr = 16'hFD00;
        emit(8'h90); emit(8'h12); emit(8'h34);
        emit(8'hB1); emit(8'hB0); emit(8'h00);
        emit(8'h3A);
        emit(8'h91); emit(8'hB0); emit(8'h00);
        do_reset();
        release_reset();
        run_cycles(18, "word");
        tests++;
        if ({dut.regs_q[0], dut.regs_q[1]} !== 16'h1234 || dut.flags_q.z !== 1'b0) begin
            fails++;
            $display("FAIL ldaw_abs: got A=%h z=%b want A=1234 z=0", {dut.regs_q[0], dut.regs_q[1]}, dut.flags_q.z);
        end
        tests++;
        if (mem[16'hB000] !== 8'h12 || mem[16'hB001] !== 8'h34) begin
            fails++;
            $display("FAIL staw bytes: got %h %h want 12 34", mem[16'hB000], mem[16'hB001]);
        end
        run_cycles(2, "word_tail");
    endtask

    task automatic test_branch_loop();
        clear_prog();
        poke(16'hF000, 8'hAA);
        ptr = 16'hFD00;
        emit(8'h80); emit(8'h03);
        emit(8'hC0); emit(8'hFF);
        emit(8'h40); emit(8'h31);
        emit(8'h15); emit(8'hFC);
        emit(8'hA1); emit(8'hF0); emit(8'h00);
        do_reset();
        release_reset();
        run_cycles(29, "loop");
        tests++;
        if (dut.regs_q[1] !== 8'h00 || dut.flags_q.z !== 1'b1 || mem[16'hF000] !== 8'h00) begin
            fails++;
            $display("FAIL loop exit: got AL=%h z=%b m=%h want 00 1 00", dut.regs_q[1], dut.flags_q.z, mem[16'hF000]);
        end
        run_cycles(2, "loop_tail");
    endtask

    task automatic test_alu_flags();
        logic [3:0] f;
        clear_prog();
        ptr = 16'hFD00;
        emit(8'h80); emit(8'h7F); emit(8'hC0); emit(8'h01); emit(8'h40); emit(8'h31);
        emit(8'h90); emit(8'hFF); emit(8'hFF); emit(8'hC0); emit(8'h01); emit(8'h58);
        do_reset();
        release_reset();
        run_cycles(9, "add");
        f = dut.flags_q;
        tests++;
        if (dut.regs_q[1] !== 8'h80 || f !== 4'b0101) begin
            fails++;
            $display("FAIL add_ovf: got AL=%h zmcv=%b want 80 0101", dut.regs_q[1], f);
        end
        run_cycles(9, "aabw");
        f = dut.flags_q;
        tests++;
        if ({dut.regs_q[2], dut.regs_q[3]} !== 16'h0000 || f !== 4'b1010) begin
            fails++;
            $display("FAIL aabw_carry: got B=%h zmcv=%b want 0000 1010", {dut.regs_q[2], dut.regs_q[3]}, f);
        end
        run_cycles(2, "aabw_tail");
    endtask

    task automatic test_reset_during_write();
        clear_prog();
        ptr = 16'hFD00;
        emit(8'h90); emit(8'h12); emit(8'h34);
        emit(8'hB1); emit(8'hB0); emit(8'h00);
        do_reset();
        release_reset();
        run_cycles(9, "staw_pre");
        tests++;
        if (write_en !== 1'b1 || address !== 16'hB001) begin
            fails++;
            $display("FAIL staw second byte: got we=%b addr=%h want 1 b001", write_en, address);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (write_en !== 1'b0 || address !== 16'hFD00 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL async reset in write: got we=%b addr=%h d=%h want 0 fd00 00", write_en, address, data_out);
        end
        do_reset();
        release_reset();
        run_cycles(8, "restart");
    endtask

    task automatic test_random();
        logic [7:0] ops [18];
        ops = '{8'h01, 8'h14, 8'h15, 8'h22, 8'h3A, 8'h3D, 8'h40, 8'h42, 8'h58,
                8'h71, 8'h80, 8'h81, 8'h90, 8'h91, 8'hA1, 8'hB1, 8'hC0, 8'hC1};
        for (int i = 0; i < 65536; i++) begin
            if ($urandom_range(0, 9) < 6) poke(16'(i), ops[$urandom_range(0, 17)]);
            else                          poke(16'(i), 8'($urandom));
        end
        do_reset();
        release_reset();
        run_cycles(3000, "random");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            mm[i]  = 8'h00;
        end
        test_reset();
        test_jmp_load_store();
        test_word();
        test_branch_loop();
        test_alu_flags();
        test_reset_during_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
